// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory bus bridge.
//   - funct3 load/store size/sign encodings
//   - bridge_state_t: bridge FSM states
//   - be_gen:       byte enables of a store for a given size and byte offset
//   - is_aligned:   size/offset legality check (unknown funct3 codes are illegal)
//   - store_lanes:  replicate store data across all lanes its size can land on
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    // funct3[1:0] carries the access size for both signed and unsigned codes.
    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   be_gen = 4'b0001 << lo;
            2'b01:   be_gen = lo[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: is_aligned = 1'b1;
            F3_H, F3_HU: is_aligned = ~lo[0];
            F3_W:        is_aligned = (lo == 2'b00);
            default:     is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        case (f3[1:0])
            2'b00:   store_lanes = {4{data[7:0]}};
            2'b01:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword out of a bus read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//   word     in  32  raw word from the bus
//   funct3   in  3   load size/sign code
//   byte_sel in  2   byte offset of the access within the word
//   data     out 32  formatted load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_sel,
    output logic [31:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[8*byte_sel +: 8];
        lane_half = byte_sel[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   data = {24'h0, lane_byte};
            F3_H:    data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   data = {16'h0, lane_half};
            F3_W:    data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: converts the core's one-cycle load/store port into a
// valid/ack transaction on a variable-latency memory bus, stalling the core
// until the access completes. Misaligned accesses are dropped with a pulse;
// hung or failed transactions finish with an error pulse and zero load data.
//   clk, reset (async, active low)
//   rd_en, wr_en, addr, wdata, funct3        core request side
//   rdata, stall, misalign, bus_err_o        core response side
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be   bus request (registered)
//   bus_ack, bus_rdata, bus_err              bus response
module data_mem_bridge
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err_o,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    bridge_state_t state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    f3_q;
    logic [1:0]    lo_q;
    logic [31:0]   load_data;
    logic          access;
    logic          aligned;

    assign access  = rd_en | wr_en;
    assign aligned = is_aligned(funct3, addr[1:0]);

    // The core must freeze in the very cycle it presents a legal access,
    // before the registered bus request is even visible.
    assign stall = reset & (((state == IDLE) & access & aligned) | (state == BUSY));

    load_align u_load_align (
        .word     (bus_rdata),
        .funct3   (f3_q),
        .byte_sel (lo_q),
        .data     (load_data)
    );

    // Ack takes priority over the timeout so an ack in the last allowed
    // cycle still completes cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            f3_q      <= 3'b000;
            lo_q      <= 2'b00;
            rdata     <= 32'h0;
            misalign  <= 1'b0;
            bus_err_o <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_be    <= 4'h0;
        end else begin
            misalign  <= 1'b0;
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            bus_req   <= 1'b1;
                            bus_we    <= wr_en;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= wr_en ? be_gen(funct3, addr[1:0]) : 4'b1111;
                            bus_wdata <= wr_en ? store_lanes(funct3, wdata) : 32'h0;
                            f3_q      <= funct3;
                            lo_q      <= addr[1:0];
                            wait_cnt  <= '0;
                            state     <= BUSY;
                        end else begin
                            misalign  <= 1'b1;
                            rdata     <= 32'h0;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        rdata     <= (bus_we | bus_err) ? 32'h0 : load_data;
                        bus_err_o <= bus_err;
                        state     <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        bus_req   <= 1'b0;
                        bus_err_o <= 1'b1;
                        rdata     <= 32'h0;
                        wait_cnt  <= wait_cnt + CW'(1);
                        state     <= DONE;
                    end else begin
                        wait_cnt  <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: self-checking bench for data_mem_bridge (TIMEOUT=4).
// A table of directed accesses with hand-derived expectations, hand-written
// sequences for misaligned accesses and reset during a transaction, then
// random accesses checked against an arithmetic reference model.
module tb_data_mem_bridge;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_err_o;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_err = 1'b0;

    int nVec = 0;
    int nMiss = 0;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdataBus;
        int          waits;
        bit          err;
        bit          withhold;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
    } accVec_t;

    data_mem_bridge #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .wdata     (wdata),
        .funct3    (funct3),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err_o (bus_err_o),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic accVec_t mkVec(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                      logic [31:0] rb, int waits, bit err, bit hold,
                                      logic [31:0] eAddr, logic [3:0] eBe,
                                      logic [31:0] eWd, logic [31:0] eRd);
        accVec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdataBus = rb;
        v.waits = waits; v.err = err; v.withhold = hold;
        v.expAddr = eAddr; v.expBe = eBe; v.expWdata = eWd; v.expRdata = eRd;
        return v;
    endfunction

    // Reference model: lane position and width from plain arithmetic.
    function automatic accVec_t modelFill(accVec_t v);
        int     size;
        int     off;
        longint lane;
        size = 1 << int'(v.f3[1:0]);
        off  = int'(v.addr[1:0]);
        v.expAddr = v.addr - 32'(off);
        v.expRdata = 32'h0;
        v.expWdata = 32'h0;
        if (v.we) begin
            v.expBe = 4'(((1 << size) - 1) << off);
            if (size == 1)      v.expWdata = 32'(v.wdata[7:0]) * 32'h01010101;
            else if (size == 2) v.expWdata = 32'(v.wdata[15:0]) * 32'h00010001;
            else                v.expWdata = v.wdata;
        end else begin
            v.expBe = 4'hF;
            lane = longint'(v.rdataBus >> (8 * off));
            if (size == 1) begin
                lane = lane % 256;
                if (!v.f3[2] && lane >= 128) lane = lane - 256;
            end else if (size == 2) begin
                lane = lane % 65536;
                if (!v.f3[2] && lane >= 32768) lane = lane - 65536;
            end
            v.expRdata = 32'(lane);
        end
        if (v.err || v.withhold) v.expRdata = 32'h0;
        return v;
    endfunction

    // Drives one aligned access, plays the bus slave, and checks the bus
    // request, stall length and DONE-cycle results.
    task automatic applyStimulus(input accVec_t v, input string nm);
        int reqCnt;
        int stallCnt;
        int expReq;
        bit done;
        expReq = v.withhold ? TO : v.waits + 1;
        reqCnt = 0;
        stallCnt = 0;
        done = 1'b0;
        @(negedge clk);
        wr_en = v.we; rd_en = !v.we; addr = v.addr; wdata = v.wdata; funct3 = v.f3;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            bus_ack = 1'b0;
            bus_err = 1'b0;
            bus_rdata = $urandom;
            if (bus_req) begin
                reqCnt++;
                checkOutput({nm, ".bus_addr"}, bus_addr, v.expAddr);
                checkOutput({nm, ".bus_be"}, 32'(bus_be), 32'(v.expBe));
                checkOutput({nm, ".bus_we"}, 32'(bus_we), 32'(v.we));
                if (v.we) checkOutput({nm, ".bus_wdata"}, bus_wdata, v.expWdata);
                if (!v.withhold && reqCnt == v.waits + 1) begin
                    bus_ack = 1'b1;
                    bus_err = v.err;
                    bus_rdata = v.rdataBus;
                end
            end
            #1;
            if (stall) begin
                stallCnt++;
            end else begin
                done = 1'b1;
                checkOutput({nm, ".rdata"}, rdata, v.expRdata);
                checkOutput({nm, ".bus_err_o"}, 32'(bus_err_o), 32'(v.err || v.withhold));
                checkOutput({nm, ".req_cycles"}, 32'(reqCnt), 32'(expReq));
                checkOutput({nm, ".stall_cycles"}, 32'(stallCnt), 32'(expReq + 1));
                checkOutput({nm, ".req_dropped"}, 32'(bus_req), 32'h0);
            end
        end
        bus_ack = 1'b0;
        bus_err = 1'b0;
        if (!done) begin
            nVec++;
            nMiss++;
            $display("[TB] FAIL %s.complete: stall still high after 40 cycles, expected DONE", nm);
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic applyMisaligned(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                   input string nm);
        @(negedge clk);
        wr_en = we; rd_en = !we; addr = a; wdata = 32'h5A5A5A5A; funct3 = f3;
        #1;
        checkOutput({nm, ".stall"}, 32'(stall), 32'h0);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        checkOutput({nm, ".misalign"}, 32'(misalign), 32'h1);
        checkOutput({nm, ".bus_req"}, 32'(bus_req), 32'h0);
        checkOutput({nm, ".rdata"}, rdata, 32'h0);
        @(negedge clk);
        #1;
        checkOutput({nm, ".misalign_end"}, 32'(misalign), 32'h0);
        checkOutput({nm, ".bus_req_end"}, 32'(bus_req), 32'h0);
    endtask

    initial begin
        accVec_t tbl[12];
        accVec_t rv;
        logic [2:0] rdCodes[5];
        rdCodes[0] = F3_B; rdCodes[1] = F3_H; rdCodes[2] = F3_W;
        rdCodes[3] = F3_BU; rdCodes[4] = F3_HU;

        tbl[0]  = mkVec(1, F3_W,  32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h104, 4'hF, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mkVec(1, F3_B,  32'h203, 32'h000000A5, 32'h0,        1, 0, 0, 32'h200, 4'h8, 32'hA5A5A5A5, 32'h0);
        tbl[2]  = mkVec(0, F3_H,  32'h302, 32'h0,        32'h80F07F81, 3, 0, 0, 32'h300, 4'hF, 32'h0, 32'hFFFF80F0);
        tbl[3]  = mkVec(0, F3_HU, 32'h302, 32'h0,        32'h80F07F81, 3, 0, 0, 32'h300, 4'hF, 32'h0, 32'h000080F0);
        tbl[4]  = mkVec(0, F3_B,  32'h300, 32'h0,        32'h80F07F81, 3, 0, 0, 32'h300, 4'hF, 32'h0, 32'hFFFFFF81);
        tbl[5]  = mkVec(0, F3_BU, 32'h301, 32'h0,        32'h80F07F81, 0, 0, 0, 32'h300, 4'hF, 32'h0, 32'h0000007F);
        tbl[6]  = mkVec(0, F3_B,  32'h302, 32'h0,        32'h80F07F81, 2, 0, 0, 32'h300, 4'hF, 32'h0, 32'hFFFFFFF0);
        tbl[7]  = mkVec(1, F3_H,  32'h00A, 32'h1234ABCD, 32'h0,        1, 0, 0, 32'h008, 4'hC, 32'hABCDABCD, 32'h0);
        tbl[8]  = mkVec(0, F3_W,  32'h010, 32'h0,        32'h12345678, 1, 0, 0, 32'h010, 4'hF, 32'h0, 32'h12345678);
        tbl[9]  = mkVec(0, F3_W,  32'h020, 32'h0,        32'h0,        0, 0, 1, 32'h020, 4'hF, 32'h0, 32'h0);
        tbl[10] = mkVec(0, F3_W,  32'h024, 32'h0,        32'hCAFEF00D, 2, 1, 0, 32'h024, 4'hF, 32'h0, 32'h0);
        tbl[11] = mkVec(1, F3_W,  32'h028, 32'h11223344, 32'h0,        0, 1, 0, 32'h028, 4'hF, 32'h11223344, 32'h0);

        // Reset state, with a request already present to show stall is held low.
        rd_en = 1'b1; funct3 = F3_W; addr = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset.stall", 32'(stall), 32'h0);
        checkOutput("reset.bus_req", 32'(bus_req), 32'h0);
        checkOutput("reset.bus_be", 32'(bus_be), 32'h0);
        checkOutput("reset.rdata", rdata, 32'h0);
        checkOutput("reset.misalign", 32'(misalign), 32'h0);
        checkOutput("reset.bus_err_o", 32'(bus_err_o), 32'h0);
        @(negedge clk);
        rd_en = 1'b0;
        reset = 1'b1;

        // Directed table, back-to-back (next access in the IDLE after DONE).
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], $sformatf("tbl%0d", i));
        end
        idleCycle();

        applyMisaligned(1'b0, F3_W,  32'h102, "mis_lw");
        applyMisaligned(1'b1, F3_H,  32'h101, "mis_sh");
        applyMisaligned(1'b0, 3'b011, 32'h000, "mis_f3_011");
        applyMisaligned(1'b0, F3_HU, 32'h303, "mis_lhu");

        // Reset asserted in the third bus_req cycle of a withheld read.
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; funct3 = F3_W; addr = 32'h40; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy.req_before", 32'(bus_req), 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("rst_busy.bus_req", 32'(bus_req), 32'h0);
        checkOutput("rst_busy.stall", 32'(stall), 32'h0);
        @(negedge clk);
        rd_en = 1'b0;
        reset = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checkOutput("rst_busy.late_ack_req", 32'(bus_req), 32'h0);
        checkOutput("rst_busy.late_ack_err", 32'(bus_err_o), 32'h0);
        checkOutput("rst_busy.late_ack_rdata", rdata, 32'h0);
        applyStimulus(mkVec(0, F3_W, 32'h0, 32'h0, 32'h0BADF00D, 1, 0, 0,
                            32'h0, 4'hF, 32'h0, 32'h0BADF00D), "rst_busy.lw0");
        idleCycle();

        // Random accesses against the reference model.
        for (int i = 0; i < 30; i++) begin
            rv.we = 1'($urandom_range(0, 1));
            rv.f3 = rv.we ? 3'($urandom_range(0, 2)) : rdCodes[$urandom_range(0, 4)];
            rv.addr = $urandom & ~(32'((1 << int'(rv.f3[1:0])) - 1));
            rv.wdata = $urandom;
            rv.rdataBus = $urandom;
            rv.waits = $urandom_range(0, TO - 1);
            rv.err = ($urandom_range(0, 7) == 0);
            rv.withhold = ($urandom_range(0, 9) == 0);
            rv = modelFill(rv);
            applyStimulus(rv, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
